// File: rtl/reg_file_wb.sv
// MIPS register file: 32 x DWIDTH, two async read ports plus a debug port, one sync write port.
// Optional write-to-read forwarding on all read ports when REGFILE_WR_BYPASS_EN is defined.
module reg_file_wb #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] rd_addr_a,
    input  logic [AWIDTH-1:0] rd_addr_b,
    output logic [DWIDTH-1:0] rd_data_a,
    output logic [DWIDTH-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] dbg_addr,
    output logic [DWIDTH-1:0] dbg_data,
    output logic              wr_ack
);

    localparam int DEPTH  = 2 ** AWIDTH;
    localparam int NPORTS = 3;

    logic [DWIDTH-1:0] r_regs [DEPTH];
    logic              r_wr_ack;
    logic              w_wr_hit;
    logic [AWIDTH-1:0] w_rd_addr [NPORTS];
    logic [DWIDTH-1:0] w_rd_data [NPORTS];

    // A write only counts when it targets a real register; $0 stays hardwired.
    assign w_wr_hit = wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_ack <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_wr_ack <= w_wr_hit;
        end
    end

    assign wr_ack = r_wr_ack;

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;
    assign w_rd_addr[2] = dbg_addr;

    // All three read ports share identical semantics, so they are built from one template.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rd_port
            logic w_fwd;
`ifdef REGFILE_WR_BYPASS_EN
            assign w_fwd = w_wr_hit && !rst && (w_rd_addr[gi] == wr_addr);
`else
            assign w_fwd = 1'b0;
`endif
            assign w_rd_data[gi] = (w_rd_addr[gi] == '0) ? '0 :
                                   w_fwd                  ? wr_data :
                                                            r_regs[w_rd_addr[gi]];
        end
    endgenerate

    assign rd_data_a = w_rd_data[0];
    assign rd_data_b = w_rd_data[1];
    assign dbg_data  = w_rd_data[2];

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- MIPS general-purpose register file: 32 x DWIDTH entries, two asynchronous read ports, one synchronous write port.
- Sits directly downstream of the 5-bit destination-register select mux (rt/rd choice); that mux output, carried through the pipeline, drives wr_addr here.
- Read ports feed the ID stage operand path.
- Register $0 is hardwired to zero.

Parameters:
- DWIDTH, 32, data width of each register and of all data ports.
- AWIDTH, 5, register address width; it equals the dest-select mux width. Depth is 2**AWIDTH (32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_addr_a  input  AWIDTH  read port A address (rs).
- rd_addr_b  input  AWIDTH  read port B address (rt).
- rd_data_a  output  DWIDTH  read port A data.
- rd_data_b  output  DWIDTH  read port B data.
- wr_en  input  1  write enable (RegWrite from WB stage).
- wr_addr  input  AWIDTH  write address (output of dest-select mux, via pipeline).
- wr_data  input  DWIDTH  write-back data.
- dbg_addr  input  AWIDTH  debug/observation read address.
- dbg_data  output  DWIDTH  debug read data; same semantics as ports A/B.
- wr_ack  output  1  registered pulse, high for one cycle after a write that actually changed storage.

Behaviour:
- Storage: array of 2**AWIDTH registers, each DWIDTH bits wide.
- Reset (clk edge with rst=1): every entry is cleared to 0 and wr_ack is cleared to 0. rst has priority over a simultaneous wr_en; that write is dropped. After the reset edge, rd_data_a, rd_data_b and dbg_data read 0 for all addresses.
- Write:
  - On a clk edge with rst=0, wr_en=1 and wr_addr!=0, the entry at wr_addr takes wr_data.
  - wr_ack goes high in the following cycle for exactly one cycle.
  - Back-to-back writes produce back-to-back wr_ack pulses.
- Writes to address 0 are ignored: storage is unchanged and wr_ack stays 0.
- wr_en=0: no storage change; wr_ack is 0 next cycle.
- Read: combinational.
  - rd_data_x = 0 when rd_addr_x==0; otherwise the current array content.
  - Zero latency from address change to data.
- Same address on A, B and dbg: all return identical data.
- Same-cycle read/write to the same nonzero address: the read returns the OLD contents. The new value is visible after the clk edge, unless the optional feature below is enabled.
- Reset mid-operation: any write in the reset cycle is lost. Reads in that cycle show pre-reset contents until the edge.
- X handling: wr_addr/wr_data are don't-care when wr_en=0. The bench drives known values on all address inputs.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: adds internal write-to-read forwarding on all three read ports (A, B, dbg). If wr_en=1, rst=0, wr_addr!=0 and rd_addr_x==wr_addr, then rd_data_x=wr_data combinationally in the same cycle. Address 0 still reads 0.
- Not defined: no forwarding; old data is returned as above. The pipeline must then handle the WB->ID hazard externally (e.g. a write-first split-cycle scheme or a stall).

Test Plan:
- Reset then read all: assert rst for 1 cycle with wr_en=1, wr_addr=5, wr_data=32'hFFFF_FFFF -> rd_data at every address 0..31 = 0; wr_ack=0.
- Basic write/read: write 32'hDEAD_BEEF to reg 8 -> next cycle rd_addr_a=8 gives 32'hDEAD_BEEF; wr_ack=1 for one cycle. rd_addr_b=9 gives 0.
- $0 protection: wr_en=1, wr_addr=0, wr_data=32'h1234_5678 -> rd_data_a at addr 0 = 0; wr_ack stays 0.
- Same-cycle collision: reg 3 holds 32'h0000_0011; write 32'h0000_0022 to reg 3 while rd_addr_a=3:
  - Without REGFILE_WR_BYPASS_EN: same cycle reads 32'h11, next cycle reads 32'h22.
  - With the macro: same cycle reads 32'h22.
- Dual read / back-to-back writes: write regs 1,2,31 with 32'hA, 32'hB, 32'hC on consecutive cycles -> wr_ack high for 3 consecutive cycles. Then rd_addr_a=31 gives 32'hC, rd_addr_b=1 gives 32'hA, and dbg_addr=2 gives 32'hB, all simultaneously.
- Reset mid-sequence: write reg 7 = 32'h55, then assert rst coincident with a write of 32'h66 to reg 7 -> reg 7 reads 0 after the edge; wr_ack=0.
